// File: rtl/bsc_ompss_axis_tid_mux.sv
// bsc_ompss_axis_tid_mux: merges two AXI-Stream sources into one, tagging each beat with its source index in m_tid.
module bsc_ompss_axis_tid_mux #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    input  logic                  s0_tlast,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    input  logic                  s1_tlast,
    output logic                  s1_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tid,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tid_q, m_tid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  grant0, grant1, slot_free, acc0, acc1;

    // Grant: a lock owns the output for a whole packet; in IDLE contention alternates away from last_grant
    always_comb begin
        grant0 = (state_q == LOCK0) ||
                 (state_q == IDLE && s0_tvalid && (!s1_tvalid || last_grant_q));
        grant1 = (state_q == LOCK1) ||
                 (state_q == IDLE && s1_tvalid && (!s0_tvalid || !last_grant_q));
    end

    assign slot_free = !m_tvalid_q || m_tready;
    assign s0_tready = rstn && grant0 && slot_free;
    assign s1_tready = rstn && grant1 && slot_free;
    assign acc0      = s0_tready && s0_tvalid;
    assign acc1      = s1_tready && s1_tvalid;

    assign m_tdata  = m_tdata_q;
    assign m_tid    = m_tid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;

    // Next state: load the output slot on accept, drain it when consumed, track lock and last grant
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_tdata_d    = m_tdata_q;
        m_tid_d      = m_tid_q;
        m_tlast_d    = m_tlast_q;
        m_tvalid_d   = m_tvalid_q;
        if (acc0) begin
            m_tdata_d    = s0_tdata;
            m_tid_d      = 1'b0;
            m_tlast_d    = s0_tlast;
            m_tvalid_d   = 1'b1;
            last_grant_d = 1'b0;
            state_d      = s0_tlast ? IDLE : LOCK0;
        end else if (acc1) begin
            m_tdata_d    = s1_tdata;
            m_tid_d      = 1'b1;
            m_tlast_d    = s1_tlast;
            m_tvalid_d   = 1'b1;
            last_grant_d = 1'b1;
            state_d      = s1_tlast ? IDLE : LOCK1;
        end else if (m_tready) begin
            m_tvalid_d   = 1'b0;
        end
    end

    // State registers; reset drops any lock and buffered beat and favours port 0 next
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            m_tdata_q    <= '0;
            m_tid_q      <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_tdata_q    <= m_tdata_d;
            m_tid_q      <= m_tid_d;
            m_tlast_q    <= m_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
        end
    end
endmodule

// File: tb/tb_bsc_ompss_axis_tid_mux.sv
// tb_bsc_ompss_axis_tid_mux: directed self-checking bench for the two-to-one tid mux.
module tb_bsc_ompss_axis_tid_mux;
    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] s0_tdata, s1_tdata, m_tdata;
    logic        s0_tvalid, s0_tlast, s0_tready;
    logic        s1_tvalid, s1_tlast, s1_tready;
    logic        m_tid, m_tlast, m_tvalid, m_tready;
    int          checks = 0;
    int          failures = 0;

    bsc_ompss_axis_tid_mux #(.DATA_WIDTH(64)) dut (
        .clk(clk), .rstn(rstn),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tid(m_tid), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] d, input logic id, input logic l);
        chk({tag, "_valid"}, {63'd0, m_tvalid}, {63'd0, v});
        if (v) begin
            chk({tag, "_data"}, m_tdata, d);
            chk({tag, "_tid"}, {63'd0, m_tid}, {63'd0, id});
            chk({tag, "_last"}, {63'd0, m_tlast}, {63'd0, l});
        end
    endtask

    initial begin
        rstn = 1'b0; m_tready = 1'b1;
        s0_tdata = 64'h100; s0_tvalid = 1'b1; s0_tlast = 1'b1;
        s1_tdata = 64'h200; s1_tvalid = 1'b1; s1_tlast = 1'b1;
        step(); step();
        chk("rst_valid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_data", m_tdata, 64'd0);
        chk("rst_tid", {63'd0, m_tid}, 64'd0);
        chk("rst_last", {63'd0, m_tlast}, 64'd0);
        chk("rst_s0_ready", {63'd0, s0_tready}, 64'd0);
        chk("rst_s1_ready", {63'd0, s1_tready}, 64'd0);

        // alternating single-beat packets
        rstn = 1'b1;
        #1;
        chk("alt_s0_ready0", {63'd0, s0_tready}, 64'd1);
        chk("alt_s1_ready0", {63'd0, s1_tready}, 64'd0);
        chk("alt_pre_valid", {63'd0, m_tvalid}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out("alt", 1'b1, (k % 2 == 0) ? 64'h100 : 64'h200, 1'(k % 2), 1'b1);
        end
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        step();
        chk_out("alt_drain", 1'b0, 64'd0, 1'b0, 1'b0);

        // s1 three-beat packet, s0 waiting from second beat
        s1_tvalid = 1'b1; s1_tdata = 64'hD1; s1_tlast = 1'b0;
        #1;
        chk("pk_s1_ready1", {63'd0, s1_tready}, 64'd1);
        step();
        chk_out("pk_d1", 1'b1, 64'hD1, 1'b1, 1'b0);
        s0_tvalid = 1'b1; s0_tdata = 64'h300; s0_tlast = 1'b1;
        s1_tdata = 64'hD2;
        #1;
        chk("pk_s0_ready_d2", {63'd0, s0_tready}, 64'd0);
        chk("pk_s1_ready_d2", {63'd0, s1_tready}, 64'd1);
        step();
        chk_out("pk_d2", 1'b1, 64'hD2, 1'b1, 1'b0);
        s1_tdata = 64'hD3; s1_tlast = 1'b1;
        #1;
        chk("pk_s0_ready_d3", {63'd0, s0_tready}, 64'd0);
        step();
        chk_out("pk_d3", 1'b1, 64'hD3, 1'b1, 1'b1);
        s1_tvalid = 1'b0;
        #1;
        chk("pk_s0_ready_after", {63'd0, s0_tready}, 64'd1);
        step();
        chk_out("pk_s0", 1'b1, 64'h300, 1'b0, 1'b1);
        s0_tvalid = 1'b0;
        step();
        chk_out("pk_drain", 1'b0, 64'd0, 1'b0, 1'b0);

        // lock on port 0 survives a four-cycle gap while s1 is valid
        s0_tvalid = 1'b1; s0_tdata = 64'hA; s0_tlast = 1'b0;
        step();
        chk_out("gap_a", 1'b1, 64'hA, 1'b0, 1'b0);
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b1; s1_tdata = 64'hE; s1_tlast = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("gap_s1_ready", {63'd0, s1_tready}, 64'd0);
            step();
            chk("gap_valid", {63'd0, m_tvalid}, 64'd0);
        end
        s0_tvalid = 1'b1; s0_tdata = 64'hB; s0_tlast = 1'b1;
        #1;
        chk("gap_s0_ready", {63'd0, s0_tready}, 64'd1);
        chk("gap_s1_ready_b", {63'd0, s1_tready}, 64'd0);
        step();
        chk_out("gap_b", 1'b1, 64'hB, 1'b0, 1'b1);
        s0_tvalid = 1'b0;
        step();
        chk_out("gap_e", 1'b1, 64'hE, 1'b1, 1'b1);
        s1_tvalid = 1'b0;
        step();
        chk_out("gap_drain", 1'b0, 64'd0, 1'b0, 1'b0);

        // backpressure holds the slot, then back-to-back drain
        s0_tvalid = 1'b1; s0_tdata = 64'h51; s0_tlast = 1'b1;
        s1_tvalid = 1'b1; s1_tdata = 64'h61; s1_tlast = 1'b1;
        step();
        chk_out("bp_p1", 1'b1, 64'h51, 1'b0, 1'b1);
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_s0_ready", {63'd0, s0_tready}, 64'd0);
            chk("bp_s1_ready", {63'd0, s1_tready}, 64'd0);
            step();
            chk_out("bp_hold", 1'b1, 64'h51, 1'b0, 1'b1);
        end
        m_tready = 1'b1;
        #1;
        chk("bp_s1_ready_rel", {63'd0, s1_tready}, 64'd1);
        step();
        chk_out("bp_q1", 1'b1, 64'h61, 1'b1, 1'b1);
        step();
        chk_out("bp_p1b", 1'b1, 64'h51, 1'b0, 1'b1);
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        step();
        chk_out("bp_drain", 1'b0, 64'd0, 1'b0, 1'b0);

        // reset in the middle of a port 1 packet
        s1_tvalid = 1'b1; s1_tdata = 64'h71; s1_tlast = 1'b0;
        step();
        chk_out("mr_r1", 1'b1, 64'h71, 1'b1, 1'b0);
        rstn = 1'b0; s0_tvalid = 1'b1; s0_tdata = 64'h81; s0_tlast = 1'b1;
        s1_tdata = 64'h72; s1_tlast = 1'b1;
        #1;
        chk("mr_s0_ready_rst", {63'd0, s0_tready}, 64'd0);
        chk("mr_s1_ready_rst", {63'd0, s1_tready}, 64'd0);
        step();
        chk("mr_valid", {63'd0, m_tvalid}, 64'd0);
        chk("mr_data", m_tdata, 64'd0);
        rstn = 1'b1;
        #1;
        chk("mr_s0_ready", {63'd0, s0_tready}, 64'd1);
        chk("mr_s1_ready", {63'd0, s1_tready}, 64'd0);
        step();
        chk_out("mr_first", 1'b1, 64'h81, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bsc_ompss_axis_tid_mux.md
BSC_OMPSS_AXIS_TID_MUX -- requirements
Module: bsc_ompss_axis_tid_mux

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 64, tdata width of all ports.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock; all state on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- s0_tdata  in  DATA_WIDTH  stream 0 data.
- s0_tvalid  in  1  stream 0 valid.
- s0_tlast  in  1  stream 0 end of packet.
- s0_tready  out  1  stream 0 ready.
- s1_tdata  in  DATA_WIDTH  stream 1 data.
- s1_tvalid  in  1  stream 1 valid.
- s1_tlast  in  1  stream 1 end of packet.
- s1_tready  out  1  stream 1 ready.
- m_tdata  out  DATA_WIDTH  merged data.
- m_tid  out  1  source index of the current beat (0 or 1).
- m_tlast  out  1  merged end of packet.
- m_tvalid  out  1  merged valid.
- m_tready  in  1  merged ready.
REQ-003 SHALL use one clock domain: clk; reset is synchronous and active-low on rstn.

Function
REQ-004 SHALL merge s0 and s1 into m, tagging each beat with m_tid equal to its source index; this is the inverse of the tid demux.
REQ-005 SHALL register all m_* outputs in a one-entry output stage; slot is free when m_tvalid=0 or m_tready=1.
REQ-006 SHALL accept a beat from port i when: grant(i) AND si_tvalid AND slot free; si_tready = grant(i) AND slot free (combinational, no dependence on si_tvalid).
REQ-007 SHALL load m_tdata/m_tid/m_tlast and set m_tvalid=1 on the edge following acceptance; latency is exactly 1 cycle.
REQ-008 SHALL clear m_tvalid when m_tready=1 and no beat is accepted in the same cycle.
REQ-009 SHALL sustain 1 beat/cycle when m_tready stays 1 and the granted source stays valid.
REQ-010 SHALL hold m_tdata/m_tid/m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-011 SHALL implement arbiter FSM states IDLE, LOCK0, LOCK1.
REQ-012 In IDLE, grant SHALL be computed combinationally:
- only one tvalid high: that port is granted.
- both high: the port not equal to last_grant is granted.
- neither high: no grant.
REQ-013 In LOCKi, grant(i) SHALL be 1 and the other port's grant 0, regardless of tvalid.
REQ-014 On an accepted beat from port i with si_tlast=0, state SHALL become LOCKi.
REQ-015 On an accepted beat from port i with si_tlast=1, state SHALL become IDLE; this holds for single-beat packets accepted in IDLE.
REQ-016 last_grant SHALL update to i on every accepted beat from port i.
REQ-017 When no beat is accepted, state SHALL remain unchanged, including LOCKi with si_tvalid=0; packets SHALL never interleave.
REQ-018 The inactive port's tvalid SHALL never influence accepts or state while locked.

Reset
REQ-019 While rstn=0 at a rising edge:
- m_tvalid=0, m_tdata=0, m_tid=0, m_tlast=0.
- state=IDLE.
- last_grant=1, so port 0 wins the first contention.
REQ-020 s0_tready and s1_tready SHALL be 0 whenever rstn=0.
REQ-021 Reset asserted mid-packet SHALL discard the lock and the buffered beat; no partial beat SHALL be emitted after rstn returns to 1.

Verification
REQ-022 Reset release, both ports valid with single-beat packets (tlast=1), m_tready=1 -> m_tid sequence 0,1,0,1 at 1 beat/cycle; first m_tvalid one cycle after first accept.
REQ-023 s1 sends 3-beat packet D1..D3 while s0 is valid from the second cycle -> m outputs D1,D2,D3 with tid=1, then s0 beat with tid=0; s0_tready=0 throughout the lock.
REQ-024 Lock with gap: s0 beat A (tlast=0) accepted, s0_tvalid=0 for 4 cycles, s1 valid -> s1_tready stays 0, state LOCK0; s0 beat B (tlast=1) then emitted before any s1 beat.
REQ-025 Backpressure: m_tready=0 for 5 cycles with beat pending -> m_tdata/m_tid/m_tlast unchanged, both s_tready=0; m_tready back to 1 -> beat consumed, next beat follows with no bubble.
REQ-026 Reset mid-packet: rstn=0 for 1 cycle during LOCK1 with m_tvalid=1 -> next cycle m_tvalid=0, state IDLE; with both ports then valid, port 0 is granted first.
